// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared decode-stage register file constants and types
package decode_pkg;

    localparam int REG_COUNT  = 8;
    localparam int REG_ADDR_W = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 3'd0;

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - combinational register read mux with hardwired zero register
module rf_read_port
    import decode_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [REG_COUNT-1:1][WIDTH-1:0] regs,
    input  reg_addr_t                       addr,
    output logic [WIDTH-1:0]                data
);

    // Register 0 has no storage, so the array index is only used for 1..7.
    always_comb begin
        data = '0;
        if (addr != ZERO_REG) begin
            data = regs[addr];
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// rtl/register_file_2r1w.sv - 8 x WIDTH register file, two async reads, one sync write
module register_file_2r1w
    import decode_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  reg_addr_t        ra,
    input  reg_addr_t        rb,
    input  logic [WIDTH-1:0] d,
    input  reg_addr_t        writeAddr,
    input  logic             writeEnable,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    logic [REG_COUNT-1:1][WIDTH-1:0] regs;

    // Writes to register 0 are dropped; reads never bypass a same-cycle write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else if (writeEnable && (writeAddr != ZERO_REG)) begin
            regs[writeAddr] <= d;
        end
    end

    rf_read_port #(.WIDTH(WIDTH)) u_read_a (
        .regs (regs),
        .addr (ra),
        .data (a)
    );

    rf_read_port #(.WIDTH(WIDTH)) u_read_b (
        .regs (regs),
        .addr (rb),
        .data (b)
    );

endmodule

// File: tb/tb_register_file_2r1w.sv
// tb/tb_register_file_2r1w.sv - scoreboard testbench for register_file_2r1w
module tb_register_file_2r1w;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       ra, rb, writeAddr;
    logic [WIDTH-1:0] d;
    logic             writeEnable;
    logic [WIDTH-1:0] a, b;

    logic [WIDTH-1:0] model [8];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] e;
    int checks   = 0;
    int failures = 0;

    register_file_2r1w #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .ra          (ra),
        .rb          (rb),
        .d           (d),
        .writeAddr   (writeAddr),
        .writeEnable (writeEnable),
        .a           (a),
        .b           (b)
    );

    always #5 clk = ~clk;

    task automatic do_edge();
        @(posedge clk);
        if (!reset && writeEnable && writeAddr != 3'd0) model[writeAddr] = d;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_model();
        writeEnable = 1'b1; writeAddr = 3'd5; d = 16'hDEAD;
        for (int c = 0; c < 2; c++) begin
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            exp_q.push_back('0);
            exp_q.push_back('0);
            do_edge();
            e = exp_q.pop_front(); checks++;
            if (a !== e) begin failures++; $display("FAIL reset_a got=%h exp=%h", a, e); end
            e = exp_q.pop_front(); checks++;
            if (b !== e) begin failures++; $display("FAIL reset_b got=%h exp=%h", b, e); end
        end
        writeEnable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int r = 1; r < 8; r++) begin
            ra = 3'(r); rb = 3'(8 - r);
            exp_q.push_back(model[r]);
            exp_q.push_back(model[8 - r]);
            #1;
            e = exp_q.pop_front(); checks++;
            if (a !== e) begin failures++; $display("FAIL post_reset_a r=%0d got=%h exp=%h", r, a, e); end
            e = exp_q.pop_front(); checks++;
            if (b !== e) begin failures++; $display("FAIL post_reset_b r=%0d got=%h exp=%h", r, b, e); end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        writeEnable = 1'b1; writeAddr = 3'd1; d = 16'h0005;
        do_edge();
        writeEnable = 1'b0; ra = 3'd1;
        exp_q.push_back(16'h0005);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a !== e) begin failures++; $display("FAIL write1_a got=%h exp=%h", a, e); end
        @(negedge clk);
        writeEnable = 1'b1; writeAddr = 3'd2; d = 16'h1234;
        do_edge();
        writeEnable = 1'b0; rb = 3'd2;
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h0005);
        #1;
        e = exp_q.pop_front(); checks++;
        if (b !== e) begin failures++; $display("FAIL write2_b got=%h exp=%h", b, e); end
        e = exp_q.pop_front(); checks++;
        if (a !== e) begin failures++; $display("FAIL write2_a_unchanged got=%h exp=%h", a, e); end
        // fill remaining registers with distinct random data and read all back
        for (int r = 3; r < 8; r++) begin
            @(negedge clk);
            writeEnable = 1'b1; writeAddr = 3'(r); d = 16'($urandom);
            do_edge();
        end
        writeEnable = 1'b0;
        for (int r = 0; r < 8; r++) begin
            ra = 3'(r); rb = 3'(7 - r);
            exp_q.push_back(model[r]);
            exp_q.push_back(model[7 - r]);
            #1;
            e = exp_q.pop_front(); checks++;
            if (a !== e) begin failures++; $display("FAIL sweep_a r=%0d got=%h exp=%h", r, a, e); end
            e = exp_q.pop_front(); checks++;
            if (b !== e) begin failures++; $display("FAIL sweep_b r=%0d got=%h exp=%h", 7 - r, b, e); end
        end
    endtask

    task automatic test_write_disabled();
        @(negedge clk);
        writeEnable = 1'b0; writeAddr = 3'd1; d = 16'h0001; ra = 3'd1;
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back(16'h0005);
            do_edge();
            e = exp_q.pop_front(); checks++;
            if (a !== e) begin failures++; $display("FAIL write_disabled c=%0d got=%h exp=%h", c, a, e); end
        end
    endtask

    task automatic test_zero_reg();
        logic [3:0] wide;
        @(negedge clk);
        writeEnable = 1'b1; writeAddr = 3'd0; d = 16'hFFFF; ra = 3'd0; rb = 3'd0;
        do_edge();
        writeEnable = 1'b0;
        exp_q.push_back('0);
        exp_q.push_back('0);
        e = exp_q.pop_front(); checks++;
        if (a !== e) begin failures++; $display("FAIL zero_reg_a got=%h exp=%h", a, e); end
        e = exp_q.pop_front(); checks++;
        if (b !== e) begin failures++; $display("FAIL zero_reg_b got=%h exp=%h", b, e); end
        wide = 4'd8;
        rb = wide[2:0];
        exp_q.push_back('0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (b !== e) begin failures++; $display("FAIL truncated_addr_b got=%h exp=%h", b, e); end
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        ra = 3'd3; rb = 3'd3; writeAddr = 3'd3; d = 16'hABCD; writeEnable = 1'b1;
        exp_q.push_back(model[3]);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a !== e) begin failures++; $display("FAIL rdw_before got=%h exp=%h", a, e); end
        exp_q.push_back(16'hABCD);
        exp_q.push_back(16'hABCD);
        do_edge();
        writeEnable = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (a !== e) begin failures++; $display("FAIL rdw_after_a got=%h exp=%h", a, e); end
        e = exp_q.pop_front(); checks++;
        if (b !== e) begin failures++; $display("FAIL rdw_after_b got=%h exp=%h", b, e); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        writeEnable = 1'b1; writeAddr = 3'd4; d = 16'h4444;
        do_edge();
        @(negedge clk);
        writeAddr = 3'd6; d = 16'h6666;
        do_edge();
        writeEnable = 1'b0; ra = 3'd4; rb = 3'd6;
        exp_q.push_back(16'h4444);
        exp_q.push_back(16'h6666);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a !== e) begin failures++; $display("FAIL preload_a got=%h exp=%h", a, e); end
        e = exp_q.pop_front(); checks++;
        if (b !== e) begin failures++; $display("FAIL preload_b got=%h exp=%h", b, e); end
        @(negedge clk);
        #2;
        reset = 1'b1;
        clear_model();
        exp_q.push_back('0);
        exp_q.push_back('0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a !== e) begin failures++; $display("FAIL async_reset_a got=%h exp=%h", a, e); end
        e = exp_q.pop_front(); checks++;
        if (b !== e) begin failures++; $display("FAIL async_reset_b got=%h exp=%h", b, e); end
        writeEnable = 1'b1; writeAddr = 3'd4; d = 16'h9999;
        do_edge();
        writeEnable = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        exp_q.push_back(model[4]);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a !== e) begin failures++; $display("FAIL write_during_reset got=%h exp=%h", a, e); end
    endtask

    initial begin
        reset = 1'b1; ra = '0; rb = '0; writeAddr = '0; d = '0; writeEnable = 1'b0;
        test_reset();
        test_write_read();
        test_write_disabled();
        test_zero_reg();
        test_read_during_write();
        test_async_reset();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
